text_writer: RTL and testbench



---
 rtl/text_writer_pkg.sv | 14 +
 rtl/text_writer_if.sv | 24 ++
 rtl/text_writer_cursor.sv | 57 +++++
 rtl/text_writer.sv | 99 +++++++++
 tb/tb_text_writer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_writer_pkg.sv
// text_writer_pkg: screen geometry, control codes and encodings shared by the text display blocks.
package text_writer_pkg;
    localparam int TW_COLS = 80;
    localparam int TW_ROWS = 60;
    localparam int TW_COL_W = 7;
    localparam int TW_ROW_W = 6;
    localparam logic [7:0] TW_CLEAR_CHAR = 8'h20;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;
    typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_SCREEN} state_e;
    typedef enum logic [2:0] {CUR_HOLD, CUR_ADV, CUR_CR, CUR_LF, CUR_BS, CUR_HOME} cur_cmd_e;
endpackage

// File: rtl/text_writer_if.sv
// text_writer_if: byte-stream handshake in, character-RAM write port and cursor out.
interface text_writer_if
    import text_writer_pkg::*;
#(
    parameter int COL_W = TW_COL_W,
    parameter int ROW_W = TW_ROW_W
);
    logic [7:0] char_data;
    logic char_valid;
    logic char_ready;
    logic wr_en;
    logic [ROW_W+COL_W-1:0] wr_addr;
    logic [7:0] wr_data;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    modport master (
        output char_data, char_valid,
        input char_ready, wr_en, wr_addr, wr_data, cur_col, cur_row
    );
    modport slave (
        input char_data, char_valid,
        output char_ready, wr_en, wr_addr, wr_data, cur_col, cur_row
    );
endinterface

// File: rtl/text_writer_cursor.sv
// text_cursor: column/row cursor counters with advance, wrap, CR, LF, BS and home.
module text_cursor
    import text_writer_pkg::*;
#(
    parameter int COLS = TW_COLS,
    parameter int ROWS = TW_ROWS,
    parameter int COL_W = TW_COL_W,
    parameter int ROW_W = TW_ROW_W
) (
    input logic clk,
    input logic rstn,
    input cur_cmd_e cmd_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o
);
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d, row_next;
    logic at_end;

    assign at_end = col_q == COL_W'(COLS - 1);
    assign row_next = row_q == ROW_W'(ROWS - 1) ? '0 : row_q + ROW_W'(1);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        case (cmd_i)
            CUR_ADV: begin
                col_d = at_end ? '0 : col_q + COL_W'(1);
                row_d = at_end ? row_next : row_q;
            end
            CUR_CR: col_d = '0;
            CUR_LF: begin
                col_d = '0;
                row_d = row_next;
            end
            CUR_BS: col_d = col_q == '0 ? col_q : col_q - COL_W'(1);
            CUR_HOME: begin
                col_d = '0;
                row_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o = col_q;
    assign row_o = row_q;
endmodule

// File: rtl/text_writer.sv
// text_writer: turns a byte stream into character-RAM writes with cursor tracking, control codes and clears.
module text_writer
    import text_writer_pkg::*;
#(
    parameter int COLS = TW_COLS,
    parameter int ROWS = TW_ROWS,
    parameter int COL_W = TW_COL_W,
    parameter int ROW_W = TW_ROW_W,
    parameter logic [7:0] CLEAR_CHAR = TW_CLEAR_CHAR
) (
    input logic clk,
    input logic rstn,
    text_writer_if.slave bus
);
    state_e state_q, state_d;
    logic [COL_W-1:0] clr_col_q, clr_col_d, col;
    logic [ROW_W-1:0] clr_row_q, clr_row_d, row;
    logic wr_en_q, wr_en_d;
    logic [ROW_W+COL_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    cur_cmd_e cmd;
    logic accept, printable, clearing, row_adv, bs_write, clr_col_end, clr_row_end, screen_done;

    text_cursor #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W)) u_cursor (
        .clk(clk),
        .rstn(rstn),
        .cmd_i(cmd),
        .col_o(col),
        .row_o(row)
    );

    assign accept = bus.char_valid && state_q == IDLE;
    assign printable = bus.char_data >= 8'h20;
    assign clearing = state_q != IDLE;
    assign row_adv = accept && (bus.char_data == CH_LF || (printable && col == COL_W'(COLS - 1)));
    assign bs_write = accept && bus.char_data == CH_BS && col != '0;
    assign clr_col_end = clr_col_q == COL_W'(COLS - 1);
    assign clr_row_end = clr_row_q == ROW_W'(ROWS - 1);
    assign screen_done = state_q == CLR_SCREEN && clr_col_end && clr_row_end;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= CLR_SCREEN;
            clr_col_q <= '0;
            clr_row_q <= '0;
        end else begin
            state_q <= state_d;
            clr_col_q <= clr_col_d;
            clr_row_q <= clr_row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = accept && bus.char_data == CH_FF ? CLR_SCREEN : row_adv ? CLR_LINE : IDLE;
            CLR_LINE: state_d = clr_col_end ? IDLE : CLR_LINE;
            CLR_SCREEN: state_d = screen_done ? IDLE : CLR_SCREEN;
            default: state_d = CLR_SCREEN;
        endcase
        clr_col_d = !clearing || clr_col_end ? '0 : clr_col_q + COL_W'(1);
        clr_row_d = state_q != CLR_SCREEN ? '0 : !clr_col_end ? clr_row_q : clr_row_end ? '0 : clr_row_q + ROW_W'(1);
    end

    // Cursor moves on the accept edge; a full-screen clear homes it on its final write.
    always_comb begin
        wr_en_d = clearing || (accept && printable) || bs_write;
        wr_addr_d = state_q == CLR_SCREEN ? {clr_row_q, clr_col_q} :
                    state_q == CLR_LINE ? {row, clr_col_q} :
                    printable ? {row, col} : {row, col - COL_W'(1)};
        wr_data_d = clearing || !printable ? CLEAR_CHAR : bus.char_data;
        cmd = !accept ? (screen_done ? CUR_HOME : CUR_HOLD) :
              printable ? CUR_ADV :
              bus.char_data == CH_CR ? CUR_CR :
              bus.char_data == CH_LF ? CUR_LF :
              bus.char_data == CH_BS ? CUR_BS : CUR_HOLD;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= wr_en_d;
            if (wr_en_d) begin
                wr_addr_q <= wr_addr_d;
                wr_data_q <= wr_data_d;
            end
        end
    end

    assign bus.char_ready = state_q == IDLE;
    assign bus.wr_en = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.cur_col = col;
    assign bus.cur_row = row;
endmodule

// File: tb/tb_text_writer.sv
// tb_text_writer: directed scenario checks for text_writer.
module tb_text_writer;
    import text_writer_pkg::*;
    localparam int CW = TW_COL_W;
    localparam int RW = TW_ROW_W;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int tests = 0;
    int fails = 0;

    text_writer_if bus();
    text_writer dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    task automatic send(input logic [7:0] c);
        int t = 0;
        while (!bus.char_ready && t < 10000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 10000) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: ready never rose for char %h", c);
        end
        bus.char_data = c;
        bus.char_valid = 1'b1;
        @(negedge clk);
        bus.char_valid = 1'b0;
    endtask

    task automatic test_reset;
        int nw = 0, cyc = 0, bad = 0;
        bus.char_valid = 1'b0;
        bus.char_data = 8'h00;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.cur_col, bus.cur_row, bus.char_ready} !== '0) begin
            fails++;
            $display("FAIL reset_values: en=%b addr=%h data=%h col=%0d row=%0d rdy=%b, want all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.cur_col, bus.cur_row, bus.char_ready);
        end
        rstn = 1'b1;
        while (!bus.char_ready && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (bus.wr_en) begin
                if (bus.wr_addr !== {RW'(nw / 80), CW'(nw % 80)} || bus.wr_data !== 8'h20) bad++;
                nw++;
            end
        end
        tests++;
        if (nw !== 4800 || cyc !== 4800) begin
            fails++;
            $display("FAIL reset_clear_count: writes=%0d cycles=%0d, want 4800/4800", nw, cyc);
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL reset_clear_addr: %0d bad writes, want 0", bad);
        end
        tests++;
        if (bus.cur_col !== 0 || bus.cur_row !== 0) begin
            fails++;
            $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", bus.cur_row, bus.cur_col);
        end
        @(negedge clk);
        tests++;
        if (bus.wr_en !== 1'b0 || bus.char_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_after: en=%b rdy=%b want 0/1", bus.wr_en, bus.char_ready);
        end
    endtask

    task automatic test_back_to_back;
        bus.char_data = 8'h41;
        bus.char_valid = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 13'h0000 || bus.wr_data !== 8'h41) begin
            fails++;
            $display("FAIL b2b_A: en=%b addr=%h data=%h want 1/0000/41", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        bus.char_data = 8'h42;
        @(negedge clk);
        bus.char_valid = 1'b0;
        tests++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 13'h0001 || bus.wr_data !== 8'h42) begin
            fails++;
            $display("FAIL b2b_B: en=%b addr=%h data=%h want 1/0001/42", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        tests++;
        if (bus.cur_col !== 2 || bus.cur_row !== 0) begin
            fails++;
            $display("FAIL b2b_cursor: got (%0d,%0d) want (0,2)", bus.cur_row, bus.cur_col);
        end
        @(negedge clk);
        tests++;
        if (bus.wr_en !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: en=%b want 0", bus.wr_en);
        end
    endtask

    task automatic test_line_wrap;
        int bad = 0, low = 0, nw = 0;
        send(CH_CR);
        tests++;
        if (bus.wr_en !== 1'b0 || bus.cur_col !== 0 || bus.cur_row !== 0) begin
            fails++;
            $display("FAIL wrap_cr: en=%b cursor (%0d,%0d) want 0 (0,0)", bus.wr_en, bus.cur_row, bus.cur_col);
        end
        bus.char_valid = 1'b1;
        for (int i = 0; i < 80; i++) begin
            bus.char_data = 8'h30 + 8'(i % 10);
            @(negedge clk);
            if (bus.wr_en !== 1'b1 || bus.wr_addr !== {RW'(0), CW'(i)} || bus.wr_data !== 8'h30 + 8'(i % 10)) bad++;
        end
        bus.char_valid = 1'b0;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL wrap_row0_writes: %0d bad, want 0", bad);
        end
        tests++;
        if (bus.cur_col !== 0 || bus.cur_row !== 1 || bus.char_ready !== 1'b0) begin
            fails++;
            $display("FAIL wrap_cursor: (%0d,%0d) rdy=%b want (1,0) 0", bus.cur_row, bus.cur_col, bus.char_ready);
        end
        bad = 0;
        while (!bus.char_ready && low < 200) begin
            low++;
            @(negedge clk);
            if (bus.wr_en) begin
                if (bus.wr_addr !== {RW'(1), CW'(nw)} || bus.wr_data !== 8'h20) bad++;
                nw++;
            end
        end
        tests++;
        if (low !== 80 || nw !== 80 || bad !== 0) begin
            fails++;
            $display("FAIL wrap_line_clear: low=%0d writes=%0d bad=%0d want 80/80/0", low, nw, bad);
        end
    endtask

    task automatic test_lf_wrap;
        int bad = 0, low = 0, nw = 0;
        for (int i = 0; i < 58; i++) send(CH_LF);
        for (int i = 0; i < 5; i++) send(8'h61);
        tests++;
        if (bus.cur_col !== 5 || bus.cur_row !== 59) begin
            fails++;
            $display("FAIL lf_setup: got (%0d,%0d) want (59,5)", bus.cur_row, bus.cur_col);
        end
        send(CH_LF);
        tests++;
        if (bus.cur_col !== 0 || bus.cur_row !== 0 || bus.wr_en !== 1'b0 || bus.char_ready !== 1'b0) begin
            fails++;
            $display("FAIL lf_wrap: (%0d,%0d) en=%b rdy=%b want (0,0) 0 0", bus.cur_row, bus.cur_col, bus.wr_en, bus.char_ready);
        end
        while (!bus.char_ready && low < 200) begin
            low++;
            @(negedge clk);
            if (bus.wr_en) begin
                if (bus.wr_addr !== {RW'(0), CW'(nw)} || bus.wr_data !== 8'h20) bad++;
                nw++;
            end
        end
        tests++;
        if (low !== 80 || nw !== 80 || bad !== 0) begin
            fails++;
            $display("FAIL lf_row0_clear: low=%0d writes=%0d bad=%0d want 80/80/0", low, nw, bad);
        end
    endtask

    task automatic test_bs_cr;
        send(CH_BS);
        tests++;
        if (bus.wr_en !== 1'b0 || bus.cur_col !== 0 || bus.cur_row !== 0) begin
            fails++;
            $display("FAIL bs_col0: en=%b (%0d,%0d) want 0 (0,0)", bus.wr_en, bus.cur_row, bus.cur_col);
        end
        for (int i = 0; i < 3; i++) send(8'h78);
        send(CH_BS);
        tests++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 13'h0002 || bus.wr_data !== 8'h20 || bus.cur_col !== 2) begin
            fails++;
            $display("FAIL bs_col3: en=%b addr=%h data=%h col=%0d want 1/0002/20/2", bus.wr_en, bus.wr_addr, bus.wr_data, bus.cur_col);
        end
        send(8'h01);
        tests++;
        if (bus.wr_en !== 1'b0 || bus.cur_col !== 2 || bus.cur_row !== 0 || bus.char_ready !== 1'b1) begin
            fails++;
            $display("FAIL ctrl_ignored: en=%b (%0d,%0d) rdy=%b want 0 (0,2) 1", bus.wr_en, bus.cur_row, bus.cur_col, bus.char_ready);
        end
        for (int i = 0; i < 38; i++) send(8'h79);
        tests++;
        if (bus.cur_col !== 40) begin
            fails++;
            $display("FAIL cr_setup: col=%0d want 40", bus.cur_col);
        end
        send(CH_CR);
        tests++;
        if (bus.wr_en !== 1'b0 || bus.cur_col !== 0 || bus.cur_row !== 0) begin
            fails++;
            $display("FAIL cr_col40: en=%b (%0d,%0d) want 0 (0,0)", bus.wr_en, bus.cur_row, bus.cur_col);
        end
    endtask

    task automatic test_reset_mid_clear;
        int nw = 0, cyc = 0, bad = 0;
        send(8'h71);
        send(8'h71);
        send(CH_FF);
        repeat (100) @(negedge clk);
        tests++;
        if (bus.char_ready !== 1'b0 || bus.wr_en !== 1'b1 || bus.cur_col !== 2) begin
            fails++;
            $display("FAIL ff_in_progress: rdy=%b en=%b col=%0d want 0/1/2", bus.char_ready, bus.wr_en, bus.cur_col);
        end
        bus.char_data = 8'h5A;
        bus.char_valid = 1'b1;
        #2 rstn = 1'b0;
        #1;
        tests++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.cur_col, bus.cur_row, bus.char_ready} !== '0) begin
            fails++;
            $display("FAIL midreset_values: en=%b addr=%h data=%h col=%0d row=%0d rdy=%b want all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.cur_col, bus.cur_row, bus.char_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        while (!bus.char_ready && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (bus.wr_en) begin
                if (bus.wr_addr !== {RW'(nw / 80), CW'(nw % 80)} || bus.wr_data !== 8'h20) bad++;
                nw++;
            end
        end
        tests++;
        if (nw !== 4800 || cyc !== 4800 || bad !== 0) begin
            fails++;
            $display("FAIL midreset_clear: writes=%0d cycles=%0d bad=%0d want 4800/4800/0", nw, cyc, bad);
        end
        tests++;
        if (bus.cur_col !== 0 || bus.cur_row !== 0) begin
            fails++;
            $display("FAIL midreset_cursor: got (%0d,%0d) want (0,0)", bus.cur_row, bus.cur_col);
        end
        @(negedge clk);
        bus.char_valid = 1'b0;
        tests++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 13'h0000 || bus.wr_data !== 8'h5A || bus.cur_col !== 1) begin
            fails++;
            $display("FAIL midreset_held_char: en=%b addr=%h data=%h col=%0d want 1/0000/5a/1",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.cur_col);
        end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_line_wrap;
        test_lf_wrap;
        test_bs_cr;
        test_reset_mid_clear;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
